wt_dcache_rd_missunit: RTL and testbench

Read-miss responder for the write-through L1 data cache. It accepts one outstanding read miss from the dcache read-port controller, either acknowledges it or orders a replay, and issues the refill or non-cacheable (NC) load to memory. It writes the returned cache line into the selected way and signals completion to the controller. It sits between the read-port controller, the cache memory write port and the memory adapter.

---
 rtl/wt_cache_pkg.sv | 56 +++++
 rtl/wt_dcache_rd_missunit_lfsr.sv | 33 +++
 rtl/wt_dcache_rd_missunit.sv | 192 +++++++++++++++++++
 tb/tb_wt_dcache_rd_missunit.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/wt_cache_pkg.sv
// Shared constants and types for the write-through L1 data cache.
// Geometry: 8 ways, 128-bit lines (16 bytes), 4 KiB per way.
package wt_cache_pkg;

    localparam int unsigned PLEN                  = 56;
    localparam int unsigned DCACHE_SET_ASSOC      = 8;
    localparam int unsigned DCACHE_LINE_WIDTH     = 128;
    localparam int unsigned DCACHE_OFFSET_WIDTH   = $clog2(DCACHE_LINE_WIDTH / 8);
    localparam int unsigned DCACHE_INDEX_WIDTH    = 12;
    localparam int unsigned DCACHE_CL_IDX_WIDTH   = DCACHE_INDEX_WIDTH - DCACHE_OFFSET_WIDTH;
    localparam int unsigned DCACHE_TAG_WIDTH      = PLEN - DCACHE_INDEX_WIDTH;
    localparam int unsigned DCACHE_WAY_IDX_WIDTH  = $clog2(DCACHE_SET_ASSOC);
    localparam int unsigned DCACHE_WORDS          = DCACHE_LINE_WIDTH / 64;
    localparam int unsigned DCACHE_WORD_SEL_WIDTH = DCACHE_OFFSET_WIDTH - 3;
    localparam int unsigned CACHE_ID_WIDTH        = 3;

    // Size encoding used for a full cache-line refill.
    localparam logic [2:0] SIZE_CACHE_LINE = 3'b111;

    // Request sent to the memory adapter.
    typedef struct packed {
        logic [PLEN-1:0]           paddr;
        logic [2:0]                size;
        logic                      nc;
        logic [CACHE_ID_WIDTH-1:0] tid;
    } dcache_req_t;

    // Read-miss unit states.
    typedef enum logic [1:0] {
        IDLE,
        MEM_REQ,
        MEM_WAIT
    } rd_miss_state_e;

    // Core configuration; cacheability is resolved upstream of the miss unit.
    typedef struct packed {
        logic [7:0]  nr_cached_regions;
        logic [63:0] cached_region_base;
    } ariane_cfg_t;

    localparam ariane_cfg_t ArianeDefaultConfig = '{
        nr_cached_regions:  8'd1,
        cached_region_base: 64'h0000_0000_8000_0000
    };

    // Convert a way index into a one-hot way-enable vector.
    function automatic logic [DCACHE_SET_ASSOC-1:0] way_onehot(
        input logic [DCACHE_WAY_IDX_WIDTH-1:0] idx
    );
        logic [DCACHE_SET_ASSOC-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/wt_dcache_rd_missunit_lfsr.sv
// 8-bit Fibonacci LFSR (taps 8,6,5,4) used for pseudo-random way replacement.
module lfsr_8bit (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       en_i,
    output logic [7:0] out_o
);

    logic [7:0] lfsr_q, lfsr_d;
    logic       feedback;

    // Next value: shift left, feedback from bit positions 8,6,5,4 (1-based).
    always_comb begin
        feedback = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
        lfsr_d   = lfsr_q;
        if (en_i) begin
            lfsr_d = {lfsr_q[6:0], feedback};
        end
    end

    // State register; seeded with all ones so the sequence never locks up at zero.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lfsr_q <= 8'hFF;
        end else begin
            // NOTE: non-blocking assignment so every flop samples pre-edge values.
            lfsr_q <= lfsr_d;
        end
    end

    assign out_o = lfsr_q;

endmodule

// File: rtl/wt_dcache_rd_missunit.sv
// Read-miss responder: accepts one outstanding read miss, replays on a
// collision with an in-flight store, fetches the line (or NC word) from
// memory and writes the refill into the chosen way.
module wt_dcache_rd_missunit
    import wt_cache_pkg::*;
#(
    parameter logic [CACHE_ID_WIDTH-1:0] RdTxId    = CACHE_ID_WIDTH'(1),
    parameter ariane_cfg_t               ArianeCfg = ArianeDefaultConfig
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    // read-port controller
    input  logic                           miss_req_i,
    output logic                           miss_ack_o,
    output logic                           miss_replay_o,
    input  logic                           miss_nc_i,
    input  logic                           miss_we_i,
    input  logic [DCACHE_SET_ASSOC-1:0]    miss_vld_bits_i,
    input  logic [PLEN-1:0]                miss_paddr_i,
    input  logic [2:0]                     miss_size_i,
    input  logic [CACHE_ID_WIDTH-1:0]      miss_id_i,
    output logic                           miss_rtrn_vld_o,
    output logic [63:0]                    miss_rtrn_data_o,
    // write buffer
    input  logic                           wr_busy_i,
    input  logic [PLEN-1:0]                wr_paddr_i,
    // memory adapter
    output logic                           mem_data_req_o,
    input  logic                           mem_data_ack_i,
    output dcache_req_t                    mem_data_o,
    input  logic                           mem_rtrn_vld_i,
    input  logic [DCACHE_LINE_WIDTH-1:0]   mem_rtrn_data_i,
    input  logic [CACHE_ID_WIDTH-1:0]      mem_rtrn_tid_i,
    // cache memory write port
    output logic                           wr_cl_vld_o,
    output logic [DCACHE_SET_ASSOC-1:0]    wr_cl_we_o,
    output logic [DCACHE_TAG_WIDTH-1:0]    wr_cl_tag_o,
    output logic [DCACHE_CL_IDX_WIDTH-1:0] wr_cl_idx_o,
    output logic [DCACHE_LINE_WIDTH-1:0]   wr_cl_data_o
);

    rd_miss_state_e                    state_q, state_d;
    logic [PLEN-1:0]                   paddr_q, paddr_d;
    logic [2:0]                        size_q, size_d;
    logic                              nc_q, nc_d;
    logic [DCACHE_SET_ASSOC-1:0]       vld_bits_q, vld_bits_d;
    logic [DCACHE_SET_ASSOC-1:0]       way_q, way_d;

    logic [7:0]                        lfsr_val;
    logic                              lfsr_en;
    logic [DCACHE_WAY_IDX_WIDTH-1:0]   inv_idx;
    logic                              all_valid;
    logic [DCACHE_SET_ASSOC-1:0]       way_sel;
    logic                              collision;
    logic [63:0]                       rtrn_words [DCACHE_WORDS];
    logic [DCACHE_WORD_SEL_WIDTH-1:0]  word_sel;
    logic                              rtrn_hit;
    logic                              unused_sink;

    // Pseudo-random replacement only moves when a cacheable miss is accepted.
    assign lfsr_en = miss_ack_o & ~miss_nc_i;

    lfsr_8bit i_lfsr (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .en_i   (lfsr_en),
        .out_o  (lfsr_val)
    );

    // Priority encoder: lowest-index invalid way (scan high to low, last write wins).
    always_comb begin
        inv_idx = '0;
        for (int i = int'(DCACHE_SET_ASSOC) - 1; i >= 0; i--) begin
            if (!miss_vld_bits_i[i]) begin
                inv_idx = DCACHE_WAY_IDX_WIDTH'(i);
            end
        end
    end

    assign all_valid = &miss_vld_bits_i;
    assign way_sel   = all_valid ? way_onehot(lfsr_val[DCACHE_WAY_IDX_WIDTH-1:0])
                                 : way_onehot(inv_idx);

    // A miss to the same line as an in-flight store could refill stale data.
    assign collision = wr_busy_i &&
        (wr_paddr_i[PLEN-1:DCACHE_OFFSET_WIDTH] == miss_paddr_i[PLEN-1:DCACHE_OFFSET_WIDTH]);

    // Split the returned line into 64-bit words for the requester.
    always_comb begin
        for (int w = 0; w < int'(DCACHE_WORDS); w++) begin
            rtrn_words[w] = mem_rtrn_data_i[w*64 +: 64];
        end
    end

    assign word_sel = paddr_q[DCACHE_OFFSET_WIDTH-1:3];
    assign rtrn_hit = mem_rtrn_vld_i && (mem_rtrn_tid_i == RdTxId);

    // Next-state and output logic of the miss FSM.
    always_comb begin
        // NOTE: every output and next-state is defaulted first so no path infers a latch.
        state_d          = state_q;
        paddr_d          = paddr_q;
        size_d           = size_q;
        nc_d             = nc_q;
        vld_bits_d       = vld_bits_q;
        way_d            = way_q;
        miss_ack_o       = 1'b0;
        miss_replay_o    = 1'b0;
        miss_rtrn_vld_o  = 1'b0;
        miss_rtrn_data_o = '0;
        mem_data_req_o   = 1'b0;
        mem_data_o       = '0;
        wr_cl_vld_o      = 1'b0;
        wr_cl_we_o       = '0;
        wr_cl_tag_o      = '0;
        wr_cl_idx_o      = '0;
        wr_cl_data_o     = '0;

        unique case (state_q)
            IDLE: begin
                if (miss_req_i) begin
                    if (collision) begin
                        miss_replay_o = 1'b1;
                    end else begin
                        miss_ack_o = 1'b1;
                        paddr_d    = miss_paddr_i;
                        size_d     = miss_size_i;
                        nc_d       = miss_nc_i;
                        vld_bits_d = miss_vld_bits_i;
                        way_d      = way_sel;
                        state_d    = MEM_REQ;
                    end
                end
            end

            MEM_REQ: begin
                mem_data_req_o   = 1'b1;
                mem_data_o.paddr = nc_q ? paddr_q
                                        : {paddr_q[PLEN-1:DCACHE_OFFSET_WIDTH],
                                           {DCACHE_OFFSET_WIDTH{1'b0}}};
                mem_data_o.size  = nc_q ? size_q : SIZE_CACHE_LINE;
                mem_data_o.nc    = nc_q;
                mem_data_o.tid   = RdTxId;
                if (mem_data_ack_i) begin
                    state_d = MEM_WAIT;
                end
            end

            MEM_WAIT: begin
                if (rtrn_hit) begin
                    miss_rtrn_vld_o  = 1'b1;
                    miss_rtrn_data_o = nc_q ? rtrn_words[0] : rtrn_words[word_sel];
                    if (!nc_q) begin
                        wr_cl_vld_o  = 1'b1;
                        wr_cl_we_o   = way_q;
                        wr_cl_tag_o  = paddr_q[PLEN-1:DCACHE_INDEX_WIDTH];
                        wr_cl_idx_o  = paddr_q[DCACHE_INDEX_WIDTH-1:DCACHE_OFFSET_WIDTH];
                        wr_cl_data_o = mem_rtrn_data_i;
                    end
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // State and latched-request registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            paddr_q    <= '0;
            size_q     <= '0;
            nc_q       <= 1'b0;
            vld_bits_q <= '0;
            way_q      <= '0;
        end else begin
            state_q    <= state_d;
            paddr_q    <= paddr_d;
            size_q     <= size_d;
            nc_q       <= nc_d;
            vld_bits_q <= vld_bits_d;
            way_q      <= way_d;
        end
    end

    // Inputs and state bits that are intentionally not consumed here.
    assign unused_sink = ^{miss_we_i, miss_id_i, vld_bits_q,
                           lfsr_val[7:DCACHE_WAY_IDX_WIDTH],
                           wr_paddr_i[DCACHE_OFFSET_WIDTH-1:0], ArianeCfg};

endmodule

// File: tb/tb_wt_dcache_rd_missunit.sv
// Directed bench for the dcache read-miss unit: a table of full miss
// transactions followed by hand-written multi-cycle corner cases.
module tb_wt_dcache_rd_missunit;
    import wt_cache_pkg::*;

    localparam logic [CACHE_ID_WIDTH-1:0] RD_TID = CACHE_ID_WIDTH'(1);

    logic                           clk_i;
    logic                           rst_ni;
    logic                           miss_req_i;
    logic                           miss_ack_o;
    logic                           miss_replay_o;
    logic                           miss_nc_i;
    logic                           miss_we_i;
    logic [DCACHE_SET_ASSOC-1:0]    miss_vld_bits_i;
    logic [PLEN-1:0]                miss_paddr_i;
    logic [2:0]                     miss_size_i;
    logic [CACHE_ID_WIDTH-1:0]      miss_id_i;
    logic                           miss_rtrn_vld_o;
    logic [63:0]                    miss_rtrn_data_o;
    logic                           wr_busy_i;
    logic [PLEN-1:0]                wr_paddr_i;
    logic                           mem_data_req_o;
    logic                           mem_data_ack_i;
    dcache_req_t                    mem_data_o;
    logic                           mem_rtrn_vld_i;
    logic [DCACHE_LINE_WIDTH-1:0]   mem_rtrn_data_i;
    logic [CACHE_ID_WIDTH-1:0]      mem_rtrn_tid_i;
    logic                           wr_cl_vld_o;
    logic [DCACHE_SET_ASSOC-1:0]    wr_cl_we_o;
    logic [DCACHE_TAG_WIDTH-1:0]    wr_cl_tag_o;
    logic [DCACHE_CL_IDX_WIDTH-1:0] wr_cl_idx_o;
    logic [DCACHE_LINE_WIDTH-1:0]   wr_cl_data_o;

    int checks   = 0;
    int failures = 0;

    wt_dcache_rd_missunit #(
        .RdTxId (RD_TID)
    ) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .miss_req_i       (miss_req_i),
        .miss_ack_o       (miss_ack_o),
        .miss_replay_o    (miss_replay_o),
        .miss_nc_i        (miss_nc_i),
        .miss_we_i        (miss_we_i),
        .miss_vld_bits_i  (miss_vld_bits_i),
        .miss_paddr_i     (miss_paddr_i),
        .miss_size_i      (miss_size_i),
        .miss_id_i        (miss_id_i),
        .miss_rtrn_vld_o  (miss_rtrn_vld_o),
        .miss_rtrn_data_o (miss_rtrn_data_o),
        .wr_busy_i        (wr_busy_i),
        .wr_paddr_i       (wr_paddr_i),
        .mem_data_req_o   (mem_data_req_o),
        .mem_data_ack_i   (mem_data_ack_i),
        .mem_data_o       (mem_data_o),
        .mem_rtrn_vld_i   (mem_rtrn_vld_i),
        .mem_rtrn_data_i  (mem_rtrn_data_i),
        .mem_rtrn_tid_i   (mem_rtrn_tid_i),
        .wr_cl_vld_o      (wr_cl_vld_o),
        .wr_cl_we_o       (wr_cl_we_o),
        .wr_cl_tag_o      (wr_cl_tag_o),
        .wr_cl_idx_o      (wr_cl_idx_o),
        .wr_cl_data_o     (wr_cl_data_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic                        nc;
        logic [DCACHE_SET_ASSOC-1:0] vld;
        logic [PLEN-1:0]             paddr;
        logic [2:0]                  size;
        logic                        busy;
        logic [PLEN-1:0]             wr_paddr;
        logic [127:0]                rdata;
        logic                        exp_replay;
        logic [DCACHE_SET_ASSOC-1:0] exp_way;
        logic [PLEN-1:0]             exp_mem_paddr;
        logic [2:0]                  exp_size;
        logic [63:0]                 exp_word;
    } vec_t;

    vec_t vecs [8];
    vec_t v_extra;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // One complete miss: request, (replay | ack, mem req with immediate ack, response).
    task automatic run_vec(input vec_t v, input string tag);
        tick();
        miss_req_i      = 1'b1;
        miss_nc_i       = v.nc;
        miss_vld_bits_i = v.vld;
        miss_paddr_i    = v.paddr;
        miss_size_i     = v.size;
        wr_busy_i       = v.busy;
        wr_paddr_i      = v.wr_paddr;
        @(negedge clk_i);
        check({tag, "_ack"},    128'(miss_ack_o),    128'(!v.exp_replay));
        check({tag, "_replay"}, 128'(miss_replay_o), 128'(v.exp_replay));
        tick();
        miss_req_i = 1'b0;
        wr_busy_i  = 1'b0;
        @(negedge clk_i);
        if (v.exp_replay) begin
            check({tag, "_noreq"}, 128'(mem_data_req_o), 128'(0));
            return;
        end
        check({tag, "_memreq"},   128'(mem_data_req_o),   128'(1));
        check({tag, "_mempaddr"}, 128'(mem_data_o.paddr), 128'(v.exp_mem_paddr));
        check({tag, "_memsize"},  128'(mem_data_o.size),  128'(v.exp_size));
        check({tag, "_memnc"},    128'(mem_data_o.nc),    128'(v.nc));
        check({tag, "_memtid"},   128'(mem_data_o.tid),   128'(RD_TID));
        mem_data_ack_i = 1'b1;
        tick();
        mem_data_ack_i  = 1'b0;
        mem_rtrn_vld_i  = 1'b1;
        mem_rtrn_tid_i  = RD_TID;
        mem_rtrn_data_i = v.rdata;
        @(negedge clk_i);
        check({tag, "_rtrnvld"},  128'(miss_rtrn_vld_o),  128'(1));
        check({tag, "_rtrndata"}, 128'(miss_rtrn_data_o), 128'(v.exp_word));
        check({tag, "_clvld"},    128'(wr_cl_vld_o),      128'(!v.nc));
        check({tag, "_clwe"},     128'(wr_cl_we_o),       128'(v.exp_way));
        if (!v.nc) begin
            check({tag, "_cltag"},  128'(wr_cl_tag_o),  128'(v.paddr[PLEN-1:12]));
            check({tag, "_clidx"},  128'(wr_cl_idx_o),  128'(v.paddr[11:4]));
            check({tag, "_cldata"}, wr_cl_data_o,       v.rdata);
        end
        tick();
        mem_rtrn_vld_i = 1'b0;
        @(negedge clk_i);
        check({tag, "_idle_rtrn"}, 128'(miss_rtrn_vld_o), 128'(0));
        check({tag, "_idle_req"},  128'(mem_data_req_o),  128'(0));
    endtask

    initial begin
        // Expected ways follow the LFSR from reset: FF -> FE -> FC -> F8 -> F0 -> E1.
        //            nc    vld          paddr             sz    busy  wr_paddr          rdata                                             rply  way         mem_paddr         msz   word
        vecs[0] = '{1'b0, 8'b1111_0111, 56'h8000_1040, 3'd3, 1'b0, 56'h0,         {64'h1111_1111_0000_0001, 64'h2222_2222_0000_0000}, 1'b0, 8'b0000_1000, 56'h8000_1040, 3'd7, 64'h2222_2222_0000_0000};
        vecs[1] = '{1'b0, 8'hFF,        56'h8000_2008, 3'd3, 1'b0, 56'h0,         {64'h3333_3333_0000_0011, 64'h4444_4444_0000_0010}, 1'b0, 8'b0100_0000, 56'h8000_2000, 3'd7, 64'h3333_3333_0000_0011};
        vecs[2] = '{1'b0, 8'hFF,        56'h8000_3000, 3'd3, 1'b0, 56'h0,         {64'h5555_5555_0000_0021, 64'h6666_6666_0000_0020}, 1'b0, 8'b0001_0000, 56'h8000_3000, 3'd7, 64'h6666_6666_0000_0020};
        vecs[3] = '{1'b1, 8'hFF,        56'h1000_0004, 3'd2, 1'b0, 56'h0,         {64'h7777_7777_0000_0031, 64'h8888_8888_0000_0030}, 1'b0, 8'b0000_0000, 56'h1000_0004, 3'd2, 64'h8888_8888_0000_0030};
        vecs[4] = '{1'b0, 8'hFF,        56'h8000_1040, 3'd3, 1'b1, 56'h8000_1048, 128'h0,                                             1'b1, 8'b0000_0000, 56'h0,         3'd0, 64'h0};
        vecs[5] = '{1'b0, 8'hFF,        56'h8000_1040, 3'd3, 1'b0, 56'h8000_1048, {64'h9999_9999_0000_0041, 64'hAAAA_AAAA_0000_0040}, 1'b0, 8'b0000_0001, 56'h8000_1040, 3'd7, 64'hAAAA_AAAA_0000_0040};
        vecs[6] = '{1'b0, 8'h00,        56'h8000_1040, 3'd3, 1'b1, 56'h8000_1050, {64'hBBBB_BBBB_0000_0051, 64'hCCCC_CCCC_0000_0050}, 1'b0, 8'b0000_0001, 56'h8000_1040, 3'd7, 64'hCCCC_CCCC_0000_0050};
        vecs[7] = '{1'b0, 8'b0111_1111, 56'h8000_5FC8, 3'd3, 1'b0, 56'h0,         {64'hDDDD_DDDD_0000_0061, 64'hEEEE_EEEE_0000_0060}, 1'b0, 8'b1000_0000, 56'h8000_5FC0, 3'd7, 64'hDDDD_DDDD_0000_0061};

        rst_ni          = 1'b0;
        miss_req_i      = 1'b0;
        miss_nc_i       = 1'b0;
        miss_we_i       = 1'b0;
        miss_vld_bits_i = '0;
        miss_paddr_i    = '0;
        miss_size_i     = '0;
        miss_id_i       = '0;
        wr_busy_i       = 1'b0;
        wr_paddr_i      = '0;
        mem_data_ack_i  = 1'b0;
        mem_rtrn_vld_i  = 1'b0;
        mem_rtrn_data_i = '0;
        mem_rtrn_tid_i  = '0;

        tick();
        tick();
        check("reset_outs", 128'(|{miss_ack_o, miss_replay_o, miss_rtrn_vld_o, miss_rtrn_data_o,
                                   mem_data_req_o, mem_data_o, wr_cl_vld_o, wr_cl_we_o,
                                   wr_cl_tag_o, wr_cl_idx_o, wr_cl_data_o}), 128'(0));
        rst_ni = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i], $sformatf("v%0d", i));
        end

        // Delayed memory ack, request while busy, then wrong-tid response before the real one.
        tick();
        miss_req_i      = 1'b1;
        miss_nc_i       = 1'b0;
        miss_vld_bits_i = 8'b1111_1110;
        miss_paddr_i    = 56'h8000_7010;
        miss_size_i     = 3'd3;
        @(negedge clk_i);
        check("dly_ack", 128'(miss_ack_o), 128'(1));
        tick();
        wr_busy_i  = 1'b1;
        wr_paddr_i = 56'h8000_7010;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk_i);
            check($sformatf("dly_req_c%0d", c),    128'(mem_data_req_o),   128'(1));
            check($sformatf("dly_paddr_c%0d", c),  128'(mem_data_o.paddr), 128'(56'h8000_7010));
            check($sformatf("dly_size_c%0d", c),   128'(mem_data_o.size),  128'(3'd7));
            check($sformatf("dly_noack_c%0d", c),  128'(miss_ack_o),       128'(0));
            check($sformatf("dly_norply_c%0d", c), 128'(miss_replay_o),    128'(0));
            tick();
        end
        miss_req_i     = 1'b0;
        wr_busy_i      = 1'b0;
        mem_data_ack_i = 1'b1;
        @(negedge clk_i);
        check("dly_req_final", 128'(mem_data_req_o), 128'(1));
        tick();
        mem_data_ack_i  = 1'b0;
        mem_rtrn_vld_i  = 1'b1;
        mem_rtrn_tid_i  = RD_TID ^ CACHE_ID_WIDTH'(1);
        mem_rtrn_data_i = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210};
        @(negedge clk_i);
        check("tid_wrong_rtrn", 128'(miss_rtrn_vld_o), 128'(0));
        check("tid_wrong_cl",   128'(wr_cl_vld_o),     128'(0));
        tick();
        mem_rtrn_tid_i = RD_TID;
        @(negedge clk_i);
        check("tid_ok_rtrn", 128'(miss_rtrn_vld_o),  128'(1));
        check("tid_ok_we",   128'(wr_cl_we_o),       128'(8'b0000_0001));
        check("tid_ok_data", 128'(miss_rtrn_data_o), 128'(64'hFEDC_BA98_7654_3210));
        tick();
        mem_rtrn_vld_i = 1'b0;

        // Reset while waiting for memory; a late response must be dropped.
        tick();
        miss_req_i      = 1'b1;
        miss_vld_bits_i = 8'hFF;
        miss_paddr_i    = 56'h8000_9000;
        @(negedge clk_i);
        check("rst_seq_ack", 128'(miss_ack_o), 128'(1));
        tick();
        miss_req_i     = 1'b0;
        mem_data_ack_i = 1'b1;
        tick();
        mem_data_ack_i = 1'b0;
        rst_ni         = 1'b0;
        #1;
        check("rst_mid_outs", 128'(|{miss_ack_o, miss_replay_o, miss_rtrn_vld_o, miss_rtrn_data_o,
                                     mem_data_req_o, mem_data_o, wr_cl_vld_o, wr_cl_we_o,
                                     wr_cl_tag_o, wr_cl_idx_o, wr_cl_data_o}), 128'(0));
        tick();
        rst_ni          = 1'b1;
        mem_rtrn_vld_i  = 1'b1;
        mem_rtrn_tid_i  = RD_TID;
        mem_rtrn_data_i = {4{32'hDEAD_BEEF}};
        @(negedge clk_i);
        check("late_rtrn", 128'(miss_rtrn_vld_o), 128'(0));
        check("late_cl",   128'(wr_cl_vld_o),     128'(0));
        check("late_req",  128'(mem_data_req_o),  128'(0));
        tick();
        mem_rtrn_vld_i = 1'b0;

        // LFSR restarts at FF after reset: all-valid misses pick way 7, then way 6.
        v_extra = '{1'b0, 8'hFF, 56'h8000_A018, 3'd3, 1'b0, 56'h0,
                    {64'h1212_1212_0000_0071, 64'h3434_3434_0000_0070}, 1'b0, 8'b1000_0000,
                    56'h8000_A010, 3'd7, 64'h1212_1212_0000_0071};
        run_vec(v_extra, "post_rst0");
        v_extra = '{1'b0, 8'hFF, 56'h8000_B020, 3'd3, 1'b0, 56'h0,
                    {64'h5656_5656_0000_0081, 64'h7878_7878_0000_0080}, 1'b0, 8'b0100_0000,
                    56'h8000_B020, 3'd7, 64'h7878_7878_0000_0080};
        run_vec(v_extra, "post_rst1");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
